i2c_master_controller: RTL and testbench

- Byte-level I2C master. Generates SCL/SDA bus sequences for i2c_slave_controller, which sits directly downstream on the same bus.
- Driven by a simple command handshake from a CPU-side register block: START, WRITE byte, READ byte, RESTART, STOP.
- Reports the received ACK and read data, then pulses done.

---
 rtl/i2c_master_controller.sv | 183 ++++++++++++++++++
 tb/tb_i2c_master_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_controller.sv
// Byte-level I2C master: START / WRITE / READ / RESTART / STOP commands are
// sequenced as quarter-SCL phases. SCL is push-pull, SDA is open-drain.
module i2c_master_controller #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] i_cmd,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_wr_data,
  input  logic       i_nack,
  output logic       o_ready,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_ack,
  output logic       o_bus_busy,
  output logic       o_scl,
  inout  wire        sda
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WRITE   = 3'd1;
  localparam logic [2:0] CMD_READ    = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  // Per-quarter line patterns, indexed by phase (bit 0 = first quarter).
  localparam logic [3:0] START_SCL = 4'b0111, START_SDA = 4'b0001;
  localparam logic [3:0] RSTRT_SCL = 4'b0110, RSTRT_SDA = 4'b0011;
  localparam logic [3:0] STOP_SCL  = 4'b1110, STOP_SDA  = 4'b1000;
  localparam logic [3:0] BIT_SCL   = 4'b0110;

  typedef enum logic [2:0] {IDLE, HOLD, START, RESTART, DATA, ACK, STOP} state_t;

  state_t        state, state_n, tgt;
  logic [QW-1:0] qcnt;
  logic [1:0]    ph, ph_n;
  logic [2:0]    bitn, bit_n;
  logic          go, wrap, done_n, active;
  logic          rd_r, nack_r, ack_s, rel, rel_n, scl_n;
  logic [7:0]    tx_r, rx;
  logic          cur_read, cur_nack;
  logic [7:0]    cur_tx;
  logic          sda_in;

  assign sda     = rel ? 1'bz : 1'b0;
  assign sda_in  = sda;
  assign wrap    = (qcnt == QW'(CLK_DIV - 1));
  assign active  = (state != IDLE) && (state != HOLD);
  // The done cycle itself is not an accept window; ready returns one clk later.
  assign o_ready = !active && !o_done;

  // Command legality: only START when the bus is free; START means RESTART when busy.
  always_comb begin
    go  = 1'b0;
    tgt = IDLE;
    if (i_cmd_valid && o_ready) begin
      if (state == IDLE) begin
        if (i_cmd == CMD_START) begin
          go  = 1'b1;
          tgt = START;
        end
      end else begin
        case (i_cmd)
          CMD_START, CMD_RESTART: begin go = 1'b1; tgt = RESTART; end
          CMD_WRITE, CMD_READ:    begin go = 1'b1; tgt = DATA;    end
          CMD_STOP:               begin go = 1'b1; tgt = STOP;    end
          default: ;
        endcase
      end
    end
  end

  // Next state / phase / bit, plus the line levels for the upcoming quarter.
  always_comb begin
    state_n  = state;
    ph_n     = ph;
    bit_n    = bitn;
    done_n   = 1'b0;
    scl_n    = o_scl;
    rel_n    = rel;
    cur_read = go ? (i_cmd == CMD_READ) : rd_r;
    cur_tx   = go ? i_wr_data : tx_r;
    cur_nack = go ? i_nack : nack_r;

    case (state)
      IDLE, HOLD: begin
        if (go) begin
          state_n = tgt;
          ph_n    = 2'd0;
          bit_n   = 3'd0;
        end
      end
      START, RESTART, STOP, ACK: begin
        if (wrap) begin
          if (ph == 2'd3) begin
            state_n = (state == STOP) ? IDLE : HOLD;
            ph_n    = 2'd0;
            done_n  = 1'b1;
          end else begin
            ph_n = ph + 2'd1;
          end
        end
      end
      DATA: begin
        if (wrap) begin
          ph_n = ph + 2'd1;
          if (ph == 2'd3) begin
            if (bitn == 3'd7) state_n = ACK;
            else              bit_n   = bitn + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Idle states keep whatever the last quarter left on the bus.
    case (state_n)
      START:   begin scl_n = START_SCL[ph_n]; rel_n = START_SDA[ph_n]; end
      RESTART: begin scl_n = RSTRT_SCL[ph_n]; rel_n = RSTRT_SDA[ph_n]; end
      STOP:    begin scl_n = STOP_SCL[ph_n];  rel_n = STOP_SDA[ph_n];  end
      DATA: begin
        scl_n = BIT_SCL[ph_n];
        rel_n = cur_read ? 1'b1 : cur_tx[3'd7 - bit_n];
      end
      ACK: begin
        scl_n = BIT_SCL[ph_n];
        rel_n = cur_read ? cur_nack : 1'b1;
      end
      default: ;
    endcase
  end

  // State, timing counters, bus lines, sampling and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      qcnt       <= '0;
      ph         <= 2'd0;
      bitn       <= 3'd0;
      rd_r       <= 1'b0;
      tx_r       <= 8'h00;
      nack_r     <= 1'b0;
      rx         <= 8'h00;
      ack_s      <= 1'b0;
      o_done     <= 1'b0;
      o_rd_data  <= 8'h00;
      o_ack      <= 1'b0;
      o_bus_busy <= 1'b0;
      o_scl      <= 1'b1;
      rel        <= 1'b1;
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      bitn   <= bit_n;
      o_done <= done_n;
      o_scl  <= scl_n;
      rel    <= rel_n;
      if (go) begin
        qcnt   <= '0;
        rd_r   <= (i_cmd == CMD_READ);
        tx_r   <= i_wr_data;
        nack_r <= i_nack;
      end else if (active) begin
        qcnt <= wrap ? '0 : qcnt + 1'b1;
      end
      // Sample on the last clk of the first SCL-high quarter.
      if (state == DATA && ph == 2'd1 && wrap) rx    <= {rx[6:0], sda_in};
      if (state == ACK  && ph == 2'd1 && wrap) ack_s <= ~sda_in;
      if (done_n) begin
        if (state == START) o_bus_busy <= 1'b1;
        if (state == STOP)  o_bus_busy <= 1'b0;
        if (state == ACK) begin
          if (rd_r) o_rd_data <= rx;
          else      o_ack     <= ack_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: behavioural open-drain slave plus a bus
// monitor that decodes START/STOP conditions and data bits from SCL/SDA.
module tb_i2c_master_controller;

  localparam int D = 25;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] i_cmd = 3'd0;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_nack = 1'b0;
  logic       o_ready, o_done, o_ack, o_bus_busy, o_scl;
  logic [7:0] o_rd_data;
  wire        sda;

  int checks = 0;
  int failures = 0;

  i2c_master_controller #(.CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
    .i_wr_data(i_wr_data), .i_nack(i_nack), .o_ready(o_ready), .o_done(o_done),
    .o_rd_data(o_rd_data), .o_ack(o_ack), .o_bus_busy(o_bus_busy),
    .o_scl(o_scl), .sda(sda)
  );

  always #5 clk = ~clk;

  pullup (sda);

  // Slave: drives the bit selected by how many SCL falls since it was armed.
  logic       slv_act = 1'b0, slv_rd = 1'b0, slv_ack = 1'b0, slv_low;
  logic [7:0] slv_byte = 8'h00;
  int         sbase = 0, sbit;
  int         nfall = 0, nstart = 0, nstop = 0, hi_evt = 0;
  logic       hi_val = 1'b1;
  logic       mon_q[$];

  assign sbit = nfall - sbase;
  assign sda  = slv_low ? 1'b0 : 1'bz;

  always_comb begin
    slv_low = 1'b0;
    if (slv_act) begin
      if (slv_rd) slv_low = (sbit >= 0 && sbit < 8) ? !slv_byte[7 - sbit] : 1'b0;
      else        slv_low = (sbit == 8) && slv_ack;
    end
  end

  // Monitor: SDA edges while SCL high are START/STOP; otherwise a bit per SCL pulse.
  always @(negedge sda) if (o_scl === 1'b1) nstart <= nstart + 1;
  always @(posedge sda) if (o_scl === 1'b1) nstop <= nstop + 1;
  always @(posedge o_scl) begin
    hi_val <= sda;
    hi_evt <= nstart + nstop;
  end
  always @(negedge o_scl) begin
    nfall <= nfall + 1;
    if (hi_evt == nstart + nstop && sda === hi_val) mon_q.push_back(hi_val);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!o_ready && w < 100) begin @(posedge clk); #1; w++; end
  endtask

  // Accepted command: returns clks from accept edge to o_done.
  task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic n,
                       input string tag, output int lat);
    wait_ready();
    i_cmd = c; i_wr_data = d; i_nack = n; i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk({tag, "_ready_drop"}, o_ready, 0);
    lat = 0;
    while (!o_done && lat < 40 * D) begin @(posedge clk); #1; lat++; end
    chk({tag, "_ready_in_done"}, o_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {o_ready, o_done}, 2'b10);
  endtask

  // Dropped command: no done pulse, no SCL activity, ready stays high.
  task automatic drop(input logic [2:0] c, input string tag);
    int dn = 0, tg = 0;
    logic s0;
    wait_ready();
    s0 = o_scl;
    i_cmd = c; i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk({tag, "_ready"}, o_ready, 1);
    repeat (8 * D) begin
      @(posedge clk); #1;
      if (o_done) dn++;
      if (o_scl !== s0) tg++;
    end
    chk({tag, "_no_done"}, dn, 0);
    chk({tag, "_no_scl"}, tg, 0);
  endtask

  task automatic ctrl(input logic [2:0] c, input string tag, input int dstart,
                      input int dstop, input logic busy);
    int lat, s0, p0;
    s0 = nstart; p0 = nstop;
    issue(c, 8'h00, 1'b0, tag, lat);
    chk({tag, "_latency"}, lat, 4 * D);
    chk({tag, "_starts"}, nstart - s0, dstart);
    chk({tag, "_stops"}, nstop - p0, dstop);
    chk({tag, "_busy"}, o_bus_busy, busy);
  endtask

  // Byte transfer; for a WRITE en = slave acks, for a READ en = master NACKs.
  task automatic xfer(input logic rd, input logic [7:0] b, input logic en,
                      input logic present, input string tag);
    int lat, base;
    logic       abit;
    logic [8:0] got9;
    base = mon_q.size();
    sbase = nfall; slv_rd = rd; slv_byte = b; slv_ack = en; slv_act = present;
    issue(rd ? 3'd2 : 3'd1, b, rd ? en : 1'b0, tag, lat);
    slv_act = 1'b0;
    abit = rd ? en : !(en && present);
    chk({tag, "_latency"}, lat, 36 * D);
    chk({tag, "_nbits"}, mon_q.size() - base, 9);
    got9 = '0;
    for (int i = 0; i < 9 && base + i < mon_q.size(); i++) got9 = {got9[7:0], mon_q[base + i]};
    chk({tag, "_bits"}, got9, {b, abit});
    if (rd) chk({tag, "_rd_data"}, o_rd_data, b);
    else    chk({tag, "_ack"}, o_ack, en && present);
    chk({tag, "_busy"}, o_bus_busy, 1);
  endtask

  initial begin
    #(5ms);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, dn;
    logic [7:0] b;
    logic rd, en;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", o_scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_busy", o_bus_busy, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    drop(3'd1, "idle_write");
    drop(3'd3, "idle_stop");
    ctrl(3'd0, "start", 1, 0, 1'b1);
    xfer(1'b0, 8'hE2, 1'b1, 1'b1, "wr_e2");
    xfer(1'b1, 8'h45, 1'b1, 1'b1, "rd_45_nack");
    xfer(1'b1, 8'hA6, 1'b0, 1'b1, "rd_a6_ack");
    for (int i = 0; i < 4; i++) begin
      rd = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      en = 1'($urandom_range(0, 1));
      xfer(rd, b, en, 1'b1, "rand");
    end
    xfer(1'b0, 8'h45, 1'b1, 1'b0, "wr_noslave");
    drop(3'($urandom_range(5, 7)), "busy_illegal");
    ctrl(3'd4, "restart", 1, 0, 1'b1);
    xfer(1'b0, 8'hE2, 1'b1, 1'b1, "wr_e2_b");
    ctrl(3'd0, "start_as_restart", 1, 0, 1'b1);
    ctrl(3'd3, "stop", 0, 1, 1'b0);
    chk("stop_scl", o_scl, 1);
    chk("stop_sda", sda, 1);
    drop(3'd1, "idle_write_after_stop");

    // Reset in the SCL-high part of WRITE bit 3.
    ctrl(3'd0, "start2", 1, 0, 1'b1);
    sbase = nfall; slv_rd = 1'b0; slv_ack = 1'b1; slv_act = 1'b1;
    wait_ready();
    i_cmd = 3'd1; i_wr_data = 8'hE2; i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    repeat (14 * D + 2) @(posedge clk);
    #1;
    chk("pre_rst_scl_high", o_scl, 1);
    chk("pre_rst_sda_bit3", sda, 0);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("arst_scl", o_scl, 1);
    chk("arst_sda", sda, 1);
    chk("arst_ready", o_ready, 1);
    chk("arst_busy", o_bus_busy, 0);
    chk("arst_done", o_done, 0);
    slv_act = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    dn = 0;
    repeat (4 * D) begin
      @(posedge clk); #1;
      if (o_done || !o_scl) dn++;
    end
    chk("post_rst_quiet", dn, 0);
    chk("post_rst_rd_data", o_rd_data, 0);
    chk("post_rst_ack", o_ack, 0);
    ctrl(3'd0, "start3", 1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
